mem_arbiter: RTL and testbench

- Shares one on-chip data-memory port between all cores of the multi-core coprocessor.
- Each core drives the level request / one-cycle response handshake. The core holds request high until it sees a response pulse, then drops request on the next cycle.
- Round-robin grant. One transaction in flight at a time. Fixed-latency synchronous RAM on the memory side.
- Sits between the core array and the shared data RAM. The instruction fetch path is not involved.

---
 rtl/mccp_pkg.sv | 12 +
 rtl/mem_arbiter_rr_picker.sv | 22 ++
 rtl/mem_arbiter.sv | 97 +++++++++
 tb/tb_mem_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mccp_pkg.sv
// mccp_pkg: widths and arbiter FSM encodings shared across the multi-core coprocessor
package mccp_pkg;
    localparam int WIDTH       = 32;
    localparam int CORE_NUM    = 2;
    localparam int STATE_WIDTH = 2;
    typedef enum logic [STATE_WIDTH-1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RESPOND = 2'd3
    } state_t;
endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// rr_picker: combinational round-robin pick of the first set request at or above ptr_i, wrapping
//   req_i  request vector, one bit per requester
//   ptr_i  index with highest priority this round
//   idx_o  winning index (equals ptr_i when nothing requests)
//   any_o  at least one request is set
module rr_picker #(
    parameter int CORE_NUM = mccp_pkg::CORE_NUM
) (
    input  logic [(1<<CORE_NUM)-1:0] req_i,
    input  logic [CORE_NUM-1:0]      ptr_i,
    output logic [CORE_NUM-1:0]      idx_o,
    output logic                     any_o
);
    localparam int N = 1 << CORE_NUM;
    // Scan from farthest to nearest so the nearest requester above ptr_i is the last write.
    always_comb begin
        idx_o = ptr_i;
        for (int k = N - 1; k >= 0; k--)
            if (req_i[ptr_i + CORE_NUM'(k)]) idx_o = ptr_i + CORE_NUM'(k);
    end
    assign any_o = |req_i;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one fixed-latency data-RAM port among all cores
//   core_request/core_wren/core_address/core_writedata  per-core request side, WIDTH-packed
//   core_response  one-cycle completion pulse to the served core
//   core_readdata  last read data, broadcast to all cores
//   mem_address/mem_writedata/mem_wren/mem_readdata  RAM side
//   grant_valid/grant_id  transaction in flight and the core being served
module mem_arbiter #(
    parameter int WIDTH        = mccp_pkg::WIDTH,
    parameter int CORE_NUM     = mccp_pkg::CORE_NUM,
    parameter int READ_LATENCY = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [(1<<CORE_NUM)-1:0]         core_request,
    input  logic [(1<<CORE_NUM)-1:0]         core_wren,
    input  logic [(1<<CORE_NUM)*WIDTH-1:0]   core_address,
    input  logic [(1<<CORE_NUM)*WIDTH-1:0]   core_writedata,
    output logic [(1<<CORE_NUM)-1:0]         core_response,
    output logic [WIDTH-1:0]                 core_readdata,
    output logic [WIDTH-1:0]                 mem_address,
    output logic [WIDTH-1:0]                 mem_writedata,
    output logic                             mem_wren,
    input  logic [WIDTH-1:0]                 mem_readdata,
    output logic                             grant_valid,
    output logic [CORE_NUM-1:0]              grant_id
);
    import mccp_pkg::*;
    localparam int N  = 1 << CORE_NUM;
    localparam int CW = $clog2(READ_LATENCY + 1);
    state_t              state_q;
    logic [CORE_NUM-1:0] rr_q, gid_q, win;
    logic [CW-1:0]       cnt_q;
    logic [WIDTH-1:0]    addr_q, wdata_q, rdata_q;
    logic [N-1:0]        resp_q;
    logic                wr_q, wren_q, gv_q, any;
    rr_picker #(.CORE_NUM(CORE_NUM)) u_pick (
        .req_i(core_request),
        .ptr_i(rr_q),
        .idx_o(win),
        .any_o(any)
    );
    // mem_wren and core_response are pulses: cleared every cycle unless the FSM re-asserts them.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rr_q    <= '0;
            gid_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            resp_q  <= '0;
            wr_q    <= 1'b0;
            wren_q  <= 1'b0;
            gv_q    <= 1'b0;
        end else begin
            wren_q <= 1'b0;
            resp_q <= '0;
            case (state_q)
                ST_IDLE: if (any) begin
                    addr_q  <= core_address[int'(win)*WIDTH +: WIDTH];
                    wdata_q <= core_writedata[int'(win)*WIDTH +: WIDTH];
                    wr_q    <= core_wren[win];
                    wren_q  <= core_wren[win];
                    gid_q   <= win;
                    gv_q    <= 1'b1;
                    state_q <= ST_ISSUE;
                end
                ST_ISSUE: if (wr_q) begin
                    resp_q[gid_q] <= 1'b1;
                    state_q       <= ST_RESPOND;
                end else begin
                    cnt_q   <= CW'(1);
                    state_q <= ST_WAIT;
                end
                ST_WAIT: if (cnt_q == CW'(READ_LATENCY)) begin
                    rdata_q       <= mem_readdata;
                    resp_q[gid_q] <= 1'b1;
                    state_q       <= ST_RESPOND;
                end else cnt_q <= cnt_q + 1'b1;
                ST_RESPOND: begin
                    rr_q    <= gid_q + 1'b1;
                    gv_q    <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
    assign core_response = resp_q;
    assign core_readdata = rdata_q;
    assign mem_address   = addr_q;
    assign mem_writedata = wdata_q;
    assign mem_wren      = wren_q;
    assign grant_valid   = gv_q;
    assign grant_id      = gid_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of the shared data-RAM arbiter at READ_LATENCY 2 and 1
module tb_mem_arbiter;
    localparam int W = 32;
    localparam int N = 4;
    logic clk = 1'b0, reset = 1'b1;
    logic [N-1:0] core_request = '0, req1 = '0, core_wren = '0;
    logic [N*W-1:0] core_address = '0, core_writedata = '0;
    logic [N-1:0] core_response, resp1;
    logic [W-1:0] core_readdata, rdata1, mem_address, maddr1, mem_writedata, mwd1, mem_readdata, mrd1;
    logic mem_wren, mwren1, grant_valid, gv1;
    logic [1:0] grant_id, gid1;
    int tests = 0, fails = 0;
    logic [W-1:0] ram0 [256], ram1 [256];
    logic [255:0] wr0 = '0, wr1 = '0;
    logic [7:0] p0a = '0, p0b = '0, p1a = '0;
    int served[$], resp_at[$];

    typedef struct {
        int         core;
        logic       wr;
        logic [W-1:0] addr, wdata, exp_rdata;
        int         exp_cyc;
    } txn_t;
    txn_t tbl[6];

    always #5 clk = ~clk;

    mem_arbiter #(.WIDTH(W), .CORE_NUM(2), .READ_LATENCY(2)) dut (
        .clk(clk), .reset(reset), .core_request(core_request), .core_wren(core_wren),
        .core_address(core_address), .core_writedata(core_writedata), .core_response(core_response),
        .core_readdata(core_readdata), .mem_address(mem_address), .mem_writedata(mem_writedata),
        .mem_wren(mem_wren), .mem_readdata(mem_readdata), .grant_valid(grant_valid), .grant_id(grant_id)
    );
    mem_arbiter #(.WIDTH(W), .CORE_NUM(2), .READ_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .core_request(req1), .core_wren(core_wren),
        .core_address(core_address), .core_writedata(core_writedata), .core_response(resp1),
        .core_readdata(rdata1), .mem_address(maddr1), .mem_writedata(mwd1),
        .mem_wren(mwren1), .mem_readdata(mrd1), .grant_valid(gv1), .grant_id(gid1)
    );

    // RAM models: unwritten words read as a fixed pattern; read data lags the address by the latency.
    function automatic logic [W-1:0] pat(input logic [7:0] a);
        return (a == 8'h10) ? 32'hDEADBEEF : {24'hA00000, a};
    endfunction
    always @(posedge clk) begin
        if (mem_wren) begin ram0[mem_address[7:0]] <= mem_writedata; wr0[mem_address[7:0]] <= 1'b1; end
        if (mwren1) begin ram1[maddr1[7:0]] <= mwd1; wr1[maddr1[7:0]] <= 1'b1; end
        p0a <= mem_address[7:0];
        p0b <= p0a;
        p1a <= maddr1[7:0];
    end
    assign mem_readdata = wr0[p0b] ? ram0[p0b] : pat(p0b);
    assign mrd1 = wr1[p1a] ? ram1[p1a] : pat(p1a);

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
        end
    endtask

    task automatic run_txn(input txn_t t);
        bit seen = 1'b0;
        core_wren[t.core] = t.wr;
        core_address[t.core*W +: W] = t.addr;
        core_writedata[t.core*W +: W] = t.wdata;
        core_request[t.core] = 1'b1;
        for (int c = 1; c <= 10 && !seen; c++) begin
            @(negedge clk);
            if (c == 1) begin
                chk("issue_addr", mem_address, t.addr);
                chk("issue_wren", W'(mem_wren), W'(t.wr));
                chk("issue_gv", W'(grant_valid), W'(1));
                chk("issue_gid", W'(grant_id), W'(t.core));
                if (t.wr) chk("issue_wdata", mem_writedata, t.wdata);
            end else chk("wren_pulse", W'(mem_wren), W'(0));
            if (core_response != '0) begin
                seen = 1'b1;
                chk("resp_vec", W'(core_response), W'(1) << t.core);
                chk("resp_cycle", W'(c), W'(t.exp_cyc));
                chk("readdata", core_readdata, t.exp_rdata);
                core_request[t.core] = 1'b0;
            end
        end
        chk("resp_seen", W'(seen), W'(1));
        @(negedge clk);
        chk("idle_gv", W'(grant_valid), W'(0));
        chk("idle_resp", W'(core_response), W'(0));
        chk("addr_hold", mem_address, t.addr);
    endtask

    // Serve until n responses; with rearm, a core re-raises its request two cycles after its response.
    task automatic service(input int n, input bit rearm);
        int hold[N];
        for (int i = 0; i < N; i++) hold[i] = 0;
        served.delete();
        resp_at.delete();
        for (int c = 1; c <= 200 && served.size() < n; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++)
                if (hold[i] != 0) begin
                    hold[i]--;
                    if (hold[i] == 0) core_request[i] = 1'b1;
                end
            if (core_response != '0) begin
                served.push_back(int'(grant_id));
                resp_at.push_back(c);
                chk("svc_onehot", W'(core_response), W'(1) << grant_id);
                chk("svc_rdata", core_readdata, {24'hA00000, 6'h0C, grant_id});
                core_request[grant_id] = 1'b0;
                if (rearm) hold[grant_id] = 2;
            end
        end
        core_request = '0;
        chk("svc_count", W'(served.size()), W'(n));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        tbl[0] = '{core: 2, wr: 1'b0, addr: 32'h10, wdata: 32'h0,        exp_rdata: 32'hDEADBEEF, exp_cyc: 4};
        tbl[1] = '{core: 0, wr: 1'b1, addr: 32'h20, wdata: 32'h1234,     exp_rdata: 32'hDEADBEEF, exp_cyc: 2};
        tbl[2] = '{core: 1, wr: 1'b0, addr: 32'h20, wdata: 32'h0,        exp_rdata: 32'h00001234, exp_cyc: 4};
        tbl[3] = '{core: 3, wr: 1'b1, addr: 32'h05, wdata: 32'hCAFEF00D, exp_rdata: 32'h00001234, exp_cyc: 2};
        tbl[4] = '{core: 0, wr: 1'b0, addr: 32'h07, wdata: 32'h0,        exp_rdata: 32'hA0000007, exp_cyc: 4};
        tbl[5] = '{core: 3, wr: 1'b0, addr: 32'h05, wdata: 32'h0,        exp_rdata: 32'hCAFEF00D, exp_cyc: 4};
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_gv", W'(grant_valid), W'(0));
        chk("rst_resp", W'(core_response), W'(0));
        chk("rst_addr", mem_address, W'(0));
        chk("rst_wren", W'(mem_wren), W'(0));
        chk("rst_rdata1", rdata1, W'(0));
        chk("rst_gid1", W'(gid1) | W'(gv1), W'(0));
        reset = 1'b0;
        foreach (tbl[i]) run_txn(tbl[i]);

        for (int i = 0; i < N; i++) core_address[i*W +: W] = 32'h30 + W'(i);
        core_wren = '0;
        core_request = 4'b1010;
        service(2, 1'b0);
        if (served.size() == 2) begin
            chk("simul_first", W'(served[0]), W'(1));
            chk("simul_second", W'(served[1]), W'(3));
            chk("simul_first_cyc", W'(resp_at[0]), W'(4));
            chk("simul_gap", W'(resp_at[1] - resp_at[0]), W'(5));
        end

        @(negedge clk);
        core_request = '1;
        service(8, 1'b1);
        for (int i = 0; i < served.size(); i++) chk("fair_order", W'(served[i]), W'(i % N));
        for (int i = 1; i < resp_at.size(); i++) chk("fair_gap", W'(resp_at[i] - resp_at[i-1]), W'(5));

        @(negedge clk);
        core_request[3] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid_gid", W'(grant_id), W'(3));
        reset = 1'b1;
        @(negedge clk);
        chk("rstmid_gv", W'(grant_valid), W'(0));
        chk("rstmid_gid", W'(grant_id), W'(0));
        chk("rstmid_resp", W'(core_response), W'(0));
        chk("rstmid_addr", mem_address, W'(0));
        chk("rstmid_rdata", core_readdata, W'(0));
        reset = 1'b0;
        seen = 1'b0;
        for (int c = 1; c <= 10 && !seen; c++) begin
            @(negedge clk);
            if (c == 1) chk("regrant_gid", W'(grant_id), W'(3));
            if (core_response != '0) begin
                seen = 1'b1;
                chk("regrant_cycle", W'(c), W'(4));
                chk("regrant_resp", W'(core_response), W'(4'b1000));
                chk("regrant_rdata", core_readdata, 32'hA0000033);
                core_request[3] = 1'b0;
            end
        end
        chk("regrant_seen", W'(seen), W'(1));

        @(negedge clk);
        core_address[0 +: W] = 32'h40;
        req1[0] = 1'b1;
        seen = 1'b0;
        for (int c = 1; c <= 10 && !seen; c++) begin
            @(negedge clk);
            if (c == 1) begin
                chk("rl1_addr", maddr1, 32'h40);
                chk("rl1_gid", W'(gid1), W'(0));
            end
            if (resp1 != '0) begin
                seen = 1'b1;
                chk("rl1_cycle", W'(c), W'(3));
                chk("rl1_resp", W'(resp1), W'(4'b0001));
                chk("rl1_rdata", rdata1, 32'hA0000040);
                req1[0] = 1'b0;
            end
        end
        chk("rl1_seen", W'(seen), W'(1));
        @(negedge clk);
        chk("rl1_idle_gv", W'(gv1), W'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
